ray_dispatch_scheduler: RTL and testbench
=========================================

// Module: ray_dispatch_scheduler
// PURPOSE
//   Frame-level sequencer sitting between the camera/object state host and the shared ray-trace core.
//   Per frame: snapshots camera position/direction, then walks every pixel in raster order, issuing
//   one ray request per pixel over a valid/ready handshake, capped by a credit limit. Returned shaded
//   colours are forwarded to the framebuffer write port; frame_done pulses once all rays have returned.
// PARAMETERS
//   H_RES    640  pixels per line (x range 0..H_RES-1, max 1024)
//   V_RES    480  lines per frame (y range 0..V_RES-1, max 1024)
//   MAX_OUT  4    max rays in flight in the trace core (1..15)
// PORTS
//   clk          in   1   system clock
//   rst_n        in   1   asynchronous active-low reset
//   frame_start  in   1   one-cycle request to render a frame; honoured only in IDLE
//   cam_pos_in   in   28  camera point {x10,y10,h8} from the object host
//   cam_dir_in   in   28  camera view vector, same packing
//   ray_valid    out  1   ray request valid
//   ray_ready    in   1   trace core accepts request
//   ray_x        out  10  pixel column of the request
//   ray_y        out  10  pixel row of the request
//   ray_origin   out  28  snapshotted camera point
//   ray_dir      out  28  snapshotted camera vector (core applies per-pixel offset)
//   res_valid    in   1   trace result valid (core always accepts; no backpressure)
//   res_addr     in   19  framebuffer address tag returned with the result
//   res_color    in   12  RGB444 colour
//   fb_we        out  1   framebuffer write strobe
//   fb_addr      out  19  framebuffer address
//   fb_data      out  12  framebuffer write data
//   busy         out  1   high in any state other than IDLE
//   frame_done   out  1   one-cycle pulse at end of frame
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; ray_valid, fb_we, busy, frame_done=0; x,y, outstanding=0;
//     ray_origin, ray_dir, fb_addr, fb_data=0. Reset mid-frame abandons the frame; in-flight results dropped.
//   FSM: IDLE -frame_start-> LATCH -> ISSUE -(last pixel accepted)-> DRAIN -(outstanding==0)-> DONE -> IDLE.
//   LATCH (1 cycle): cam_pos_in/cam_dir_in registered into ray_origin/ray_dir; x=y=0. Held constant
//     for the whole frame regardless of host updates.
//   ISSUE: ray_valid = (outstanding < MAX_OUT). Handshake = ray_valid & ray_ready.
//     ray_x/ray_y/ray_origin/ray_dir stable while ray_valid & !ray_ready; ray_valid never drops
//     without a handshake unless credits are exhausted before assertion (it is never retracted once high).
//   Raster advance on handshake: x+1; at x==H_RES-1, x=0 and y+1; handshake at (H_RES-1,V_RES-1)
//     -> DRAIN, ray_valid=0 next cycle.
//   outstanding (4 bit): +1 on handshake, -1 on res_valid, unchanged when both in the same cycle;
//     res_valid with outstanding==0 (stray/after reset) ignored for counting but still written to fb.
//   Results: fb_we/fb_addr/fb_data = registered res_valid/res_addr/res_color, 1-cycle latency, any state.
//   DRAIN: waits for outstanding==0 (inclusive of a return in the entry cycle).
//   DONE (1 cycle): frame_done=1; busy still 1; next cycle IDLE, busy=0.
//   frame_start outside IDLE ignored (not queued). frame_start in DONE cycle ignored.
//   Throughput: 1 ray/cycle when ray_ready=1 and credits available.
// TESTING
//   H_RES=4,V_RES=2,MAX_OUT=2, ready=1, results returned 3 cycles after issue -> 8 rays
//     (0,0)..(3,1) in raster order, frame_done pulses once, busy low next cycle.
//   frame_start with cam_pos_in=28'h1234567, change cam_pos_in mid-frame -> every ray_origin=28'h1234567.
//   MAX_OUT=2, no results returned -> exactly 2 handshakes, then ray_valid stays 0; one result
//     -> ray_valid reasserts within 1 cycle with next pixel (2,0).
//   ray_ready toggled 1010.. -> payload held stable during stalls, no pixel skipped or duplicated.
//   res_valid coinciding with a handshake at outstanding==MAX_OUT-1 -> count unchanged; res_addr=19'h00005,
//     res_color=12'hF0A -> fb_we=1, fb_addr=5, fb_data=F0A one cycle later.
//   rst_n pulsed low mid-ISSUE, then frame_start -> outputs at reset values, new frame restarts at (0,0)
//     and completes normally; second frame_start while busy -> ignored.

Source files
------------

// File: rtl/ray_dispatch_scheduler.sv
// Frame sequencer: snapshots the camera, issues one ray per pixel in raster order under a
// credit limit, and forwards returned colours to the framebuffer write port.
module ray_dispatch_scheduler #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int MAX_OUT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic [27:0] cam_pos_in,
  input  logic [27:0] cam_dir_in,
  output logic        ray_valid,
  input  logic        ray_ready,
  output logic [9:0]  ray_x,
  output logic [9:0]  ray_y,
  output logic [27:0] ray_origin,
  output logic [27:0] ray_dir,
  input  logic        res_valid,
  input  logic [18:0] res_addr,
  input  logic [11:0] res_color,
  output logic        fb_we,
  output logic [18:0] fb_addr,
  output logic [11:0] fb_data,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [2:0] {IDLE, LATCH, ISSUE, DRAIN, DONE} state_t;

  state_t      state, state_nx;
  logic [9:0]  x, y;
  logic [3:0]  outstanding;
  logic        credit_ok, handshake, last_x, last_pix, cnt_dec;

  assign credit_ok = outstanding < 4'(MAX_OUT);
  assign ray_valid = (state == ISSUE) && credit_ok;
  assign handshake = ray_valid && ray_ready;
  assign last_x    = (x == 10'(H_RES - 1));
  assign last_pix  = last_x && (y == 10'(V_RES - 1));
  // A return with nothing outstanding is a stray; it is still written but not counted.
  assign cnt_dec   = res_valid && (outstanding != 4'd0);
  assign ray_x     = x;
  assign ray_y     = y;

  always_comb begin
    state_nx   = state;
    busy       = (state != IDLE);
    frame_done = (state == DONE);
    case (state)
      IDLE:    if (frame_start) state_nx = LATCH;
      LATCH:   state_nx = ISSUE;
      ISSUE:   if (handshake && last_pix) state_nx = DRAIN;
      DRAIN:   if (outstanding == 4'd0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x          <= '0;
      y          <= '0;
      ray_origin <= '0;
      ray_dir    <= '0;
    end else if (state == LATCH) begin
      x          <= '0;
      y          <= '0;
      ray_origin <= cam_pos_in;
      ray_dir    <= cam_dir_in;
    end else if (handshake) begin
      if (last_x) begin
        x <= '0;
        y <= last_pix ? 10'd0 : y + 10'd1;
      end else begin
        x <= x + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      case ({handshake, cnt_dec})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Result forwarding: one register stage, active in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else begin
      fb_we   <= res_valid;
      fb_addr <= res_addr;
      fb_data <= res_color;
    end
  end

endmodule

// File: tb/tb_ray_dispatch_scheduler.sv
// Bench for ray_dispatch_scheduler: 4x2 frame, two credits, with a small trace-core model
// and scoreboards for issued pixels and framebuffer writes.
module tb_ray_dispatch_scheduler;
  localparam int H = 4;
  localparam int V = 2;
  localparam int MO = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [27:0] cam_pos_in = '0;
  logic [27:0] cam_dir_in = '0;
  logic        ray_valid;
  logic        ray_ready = 1'b1;
  logic [9:0]  ray_x, ray_y;
  logic [27:0] ray_origin, ray_dir;
  logic        res_valid = 1'b0;
  logic [18:0] res_addr = '0;
  logic [11:0] res_color = '0;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic [11:0] fb_data;
  logic        busy, frame_done;

  ray_dispatch_scheduler #(.H_RES(H), .V_RES(V), .MAX_OUT(MO)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .cam_pos_in(cam_pos_in), .cam_dir_in(cam_dir_in),
    .ray_valid(ray_valid), .ray_ready(ray_ready), .ray_x(ray_x), .ray_y(ray_y),
    .ray_origin(ray_origin), .ray_dir(ray_dir),
    .res_valid(res_valid), .res_addr(res_addr), .res_color(res_color),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [27:0] o;
    logic [27:0] d;
  } pix_t;

  typedef struct packed {
    int         due;
    logic [9:0] x;
    logic [9:0] y;
  } ret_t;

  pix_t        pix_q[$];
  ret_t        ret_q[$];
  logic [30:0] fb_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int hs_count = 0;
  int done_count = 0;
  logic        auto_ret = 1'b1;
  logic        toggle = 1'b0;
  logic        man_valid = 1'b0;
  logic [18:0] man_addr = '0;
  logic [11:0] man_color = '0;
  logic        stall_prev = 1'b0;
  pix_t        held;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [27:0] o, input logic [27:0] d);
    for (int yy = 0; yy < V; yy++)
      for (int xx = 0; xx < H; xx++)
        pix_q.push_back('{x: 10'(xx), y: 10'(yy), o: o, d: d});
  endtask

  // One clock: observe at the falling edge, then model the trace core after the rising edge.
  task automatic step();
    pix_t cur, e;
    logic [30:0] f;
    ret_t r;
    @(negedge clk);
    cur = '{x: ray_x, y: ray_y, o: ray_origin, d: ray_dir};
    if (fb_q.size() > 0) begin
      f = fb_q.pop_front();
      check("fb_write", {fb_we, fb_addr, fb_data}, {1'b1, f});
    end else if (fb_we) begin
      check("fb_spurious", fb_we, 1'b0);
    end
    if (res_valid) fb_q.push_back({res_addr, res_color});
    if (stall_prev) begin
      check("stall_valid_held", ray_valid, 1'b1);
      check("stall_payload_held", cur, held);
    end
    if (ray_valid && ray_ready) begin
      hs_count++;
      if (pix_q.size() == 0) begin
        check("unexpected_ray", cur, '0);
      end else begin
        e = pix_q.pop_front();
        check("ray_payload", cur, e);
      end
      if (auto_ret) ret_q.push_back('{due: cyc + 3, x: ray_x, y: ray_y});
    end
    stall_prev = ray_valid && !ray_ready;
    held = cur;
    if (frame_done) done_count++;
    @(posedge clk);
    cyc++;
    #1;
    res_valid = 1'b0;
    if (man_valid) begin
      res_valid = 1'b1;
      res_addr  = man_addr;
      res_color = man_color;
      man_valid = 1'b0;
    end else if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
      r = ret_q.pop_front();
      res_valid = 1'b1;
      res_addr  = 19'(r.y * H + r.x);
      res_color = {r.x[3:0], r.y[3:0], 4'hC};
    end
    if (toggle) ray_ready = ~ray_ready;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    d0 = done_count;
    for (int i = 0; i < budget && done_count == d0; i++) step();
    check(tag, done_count - d0, 1);
    check({tag, "_busy_low"}, busy, 1'b0);
  endtask

  task automatic start_frame(input logic [27:0] o, input logic [27:0] d);
    cam_pos_in = o;
    cam_dir_in = d;
    push_frame(o, d);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  initial begin
    #2;
    check("rst_ray_valid", ray_valid, 1'b0);
    check("rst_busy_done", {busy, frame_done}, 2'b00);
    check("rst_fb", {fb_we, fb_addr, fb_data}, '0);
    check("rst_payload", {ray_x, ray_y, ray_origin, ray_dir}, '0);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Full frame, camera input changed after the snapshot.
    start_frame(28'h1234567, 28'h0ABCDEF);
    check("busy_in_frame", busy, 1'b1);
    repeat (3) step();
    cam_pos_in = 28'hFFFFFFF;
    cam_dir_in = 28'h0000001;
    wait_done("frame1_done", 200);
    repeat (4) step();
    check("frame1_all_pixels", pix_q.size(), 0);
    check("frame1_hs_count", hs_count, H * V);
    check("frame1_single_done", done_count, 1);

    // Credit exhaustion with no returns.
    auto_ret = 1'b0;
    hs_count = 0;
    start_frame(28'h0000111, 28'h0000222);
    repeat (8) step();
    check("credit_hs_count", hs_count, MO);
    check("credit_valid_low", ray_valid, 1'b0);
    man_addr = 19'd0; man_color = 12'h111; man_valid = 1'b1;
    step();
    step();
    check("credit_reassert", {ray_valid, ray_x, ray_y}, {1'b1, 10'd2, 10'd0});
    auto_ret = 1'b1;
    man_addr = 19'd1; man_color = 12'h222; man_valid = 1'b1;
    wait_done("frame2_done", 200);
    repeat (4) step();
    check("frame2_all_pixels", pix_q.size(), 0);

    // Ready toggling every cycle.
    toggle = 1'b1;
    hs_count = 0;
    start_frame(28'h7654321, 28'h0F0F0F0);
    wait_done("frame3_done", 300);
    toggle = 1'b0;
    ray_ready = 1'b1;
    repeat (4) step();
    check("frame3_all_pixels", pix_q.size(), 0);
    check("frame3_hs_count", hs_count, H * V);

    // Return coinciding with a handshake at one credit left.
    auto_ret = 1'b0;
    hs_count = 0;
    start_frame(28'h0333333, 28'h0444444);
    step();
    man_addr = 19'h00005; man_color = 12'hF0A; man_valid = 1'b1;
    step();
    step();
    check("coincide_valid_kept", ray_valid, 1'b1);
    check("coincide_fb", {fb_we, fb_addr, fb_data}, {1'b1, 19'h00005, 12'hF0A});
    step();
    step();
    check("coincide_hs_count", hs_count, 3);
    check("coincide_then_full", ray_valid, 1'b0);
    check("coincide_busy", busy, 1'b1);

    // Asynchronous reset mid-frame, then a clean frame with a stray start while busy.
    rst_n = 1'b0;
    #1;
    check("midrst_ctrl", {ray_valid, busy, frame_done, fb_we}, 4'b0000);
    check("midrst_data", {ray_x, ray_y, ray_origin, ray_dir, fb_addr, fb_data}, '0);
    pix_q.delete();
    ret_q.delete();
    fb_q.delete();
    stall_prev = 1'b0;
    auto_ret = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    hs_count = 0;
    done_count = 0;
    start_frame(28'h0555555, 28'h0666666);
    repeat (3) step();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    wait_done("frame5_done", 200);
    repeat (10) step();
    check("frame5_all_pixels", pix_q.size(), 0);
    check("frame5_hs_count", hs_count, H * V);
    check("frame5_no_restart", {busy, 32'(done_count)}, {1'b0, 32'd1});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
